// File: rtl/pb_release_db.sv
// pb_release_db: debounced active-low push-button with release, long-press and level outputs
// Ports: clk system clock; rst_n sync active-low reset; PB raw button (0 = pressed, async);
//        released one-cycle pulse on accepted release; pb_pressed debounced level;
//        long_press one-cycle pulse once the hold reaches LONG_CLKS.
module pb_release_db #(
  parameter int DEBOUNCE_CLKS = 1000000,
  parameter int LONG_CLKS = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic PB,
  output logic released,
  output logic pb_pressed,
  output logic long_press
);
  localparam int DW = $clog2(DEBOUNCE_CLKS) + 1;
  localparam int HW = $clog2(LONG_CLKS) + 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CLKS - 1);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_CLKS - 1);
  typedef enum logic [2:0] {IDLE, PRESS_DB, HELD, LONG_HELD, REL_DB} state_t;
  state_t st;
  logic s1, pb_sync, lng;
  logic [DW-1:0] db;
  logic [HW-1:0] hold;
  logic diff, accept, run, hit;
  // pb_sync is active-low while pb_pressed is active-high, so equality means "differs from accepted level"
  assign diff = pb_sync == pb_pressed;
  assign accept = diff && db == DB_LAST;
  // hold counter runs from press acceptance until it saturates at LONG_CLKS
  assign run = (st == HELD || st == REL_DB) && !lng;
  assign hit = run && hold == H_LAST;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      pb_sync <= 1'b1;
      st <= IDLE;
      db <= '0;
      hold <= '0;
      lng <= 1'b0;
      released <= 1'b0;
      pb_pressed <= 1'b0;
      long_press <= 1'b0;
    end else begin
      s1 <= PB;
      pb_sync <= s1;
      db <= (diff && !accept) ? db + 1'b1 : '0;
      released <= 1'b0;
      long_press <= hit;
      if (run) hold <= hold + 1'b1;
      if (hit) lng <= 1'b1;
      case (st)
        IDLE: if (!pb_sync) st <= PRESS_DB;
        PRESS_DB:
          if (pb_sync) st <= IDLE;
          else if (accept) begin
            st <= HELD;
            pb_pressed <= 1'b1;
            hold <= '0;
          end
        HELD: if (pb_sync) st <= REL_DB; else if (hit) st <= LONG_HELD;
        LONG_HELD: if (pb_sync) st <= REL_DB;
        REL_DB:
          if (!pb_sync) st <= (lng || hit) ? LONG_HELD : HELD;
          else if (accept) begin
            st <= IDLE;
            released <= 1'b1;
            pb_pressed <= 1'b0;
            lng <= 1'b0;
          end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pb_release_db.sv
// tb_pb_release_db: directed and random stimulus checked against a sample-window model
module tb_pb_release_db;
  localparam int D = 4;
  localparam int L = 20;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pb = 1'b1;
  logic released, pb_pressed, long_press;
  int pass_n = 0, total_n = 0;
  bit m1, m2, acc, er, el;
  bit hist[$];
  int ed = 0, pe = 0;
  int nrel = 0, nlong = 0;

  pb_release_db #(.DEBOUNCE_CLKS(D), .LONG_CLKS(L)) dut (
    .clk(clk), .rst_n(rst_n), .PB(pb),
    .released(released), .pb_pressed(pb_pressed), .long_press(long_press)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic a, logic e);
    total_n++;
    if (a === e) pass_n++;
    else $display("FAIL %s: got %b want %b at t=%0t", nm, a, e, $time);
  endtask

  task automatic chki(string nm, int a, int e);
    total_n++;
    if (a == e) pass_n++;
    else $display("FAIL %s: got %0d want %0d at t=%0t", nm, a, e, $time);
  endtask

  // Model: level flips once the last D synchronised samples all disagree with it;
  // long fires exactly L edges after press acceptance while still pressed.
  task automatic model_edge();
    bit q, all;
    if (!rst_n) begin
      m1 = 1; m2 = 1; acc = 0; er = 0; el = 0;
      hist.delete();
    end else begin
      q = m2; m2 = m1; m1 = pb;
      hist.push_back(q);
      if (hist.size() > D) void'(hist.pop_front());
      all = hist.size() == D;
      foreach (hist[i]) if (hist[i] != acc) all = 0;
      el = acc && (ed - pe == L);
      er = all && acc;
      if (all) begin
        acc = !acc;
        if (acc) pe = ed;
        hist.delete();
      end
    end
    ed++;
  endtask

  task automatic cyc(logic p, logic r);
    pb = p;
    rst_n = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("released", released, er);
    chk("pb_pressed", pb_pressed, acc);
    chk("long_press", long_press, el);
    nrel += int'(released);
    nlong += int'(long_press);
  endtask

  initial begin
    int rise, fall, lp, seen;
    repeat (3) cyc(1, 0);
    nrel = 0; nlong = 0; seen = 0;
    repeat (50) begin
      cyc(1, 1);
      if (pb_pressed) seen = 1;
    end
    chki("idle_quiet", nrel + nlong + seen, 0);
    // clean press and release
    rise = -1; fall = -1;
    for (int i = 1; i <= 10; i++) begin
      cyc(0, 1);
      if (pb_pressed && rise < 0) rise = i;
    end
    chki("press_latency", rise, D + 2);
    for (int i = 1; i <= 10; i++) begin
      cyc(1, 1);
      if (!pb_pressed && fall < 0) fall = i;
    end
    chki("release_latency", fall, D + 2);
    chki("clean_rel_count", nrel, 1);
    chki("clean_long_count", nlong, 0);
    // short glitches never accepted
    nrel = 0; seen = 0;
    repeat (5) begin
      repeat (3) begin cyc(0, 1); if (pb_pressed) seen = 1; end
      cyc(1, 1);
    end
    repeat (10) cyc(1, 1);
    chki("glitch_rel", nrel, 0);
    chki("glitch_press", seen, 0);
    // bouncing press
    cyc(0, 1); cyc(1, 1); cyc(0, 1); cyc(1, 1);
    nrel = 0; rise = -1;
    for (int i = 1; i <= 10; i++) begin
      cyc(0, 1);
      if (pb_pressed && rise < 0) rise = i;
    end
    chki("bounce_latency", rise, D + 2);
    repeat (10) cyc(1, 1);
    chki("bounce_rel", nrel, 1);
    // long press
    nrel = 0; nlong = 0; rise = -1; lp = -1;
    for (int i = 1; i <= 40; i++) begin
      cyc(0, 1);
      if (pb_pressed && rise < 0) rise = i;
      if (long_press && lp < 0) lp = i;
    end
    chki("long_delay", lp - rise, L);
    repeat (10) cyc(1, 1);
    chki("long_rel", nrel, 1);
    chki("long_count", nlong, 1);
    // reset while release is being debounced
    repeat (10) cyc(0, 1);
    nrel = 0;
    repeat (4) cyc(1, 1);
    cyc(1, 0);
    chk("rst_pressed", pb_pressed, 1'b0);
    chk("rst_released", released, 1'b0);
    repeat (10) cyc(1, 1);
    chki("rst_no_pulse", nrel, 0);
    repeat (10) cyc(0, 1);
    repeat (10) cyc(1, 1);
    chki("post_rst_rel", nrel, 1);
    // random
    repeat (400) begin
      int r, len;
      bit lvl;
      r = $urandom_range(0, 99);
      lvl = 1'($urandom_range(0, 1));
      len = (r > 90) ? $urandom_range(18, 30) : $urandom_range(1, 7);
      if (r < 3) cyc(lvl, 0);
      else repeat (len) cyc(lvl, 1);
    end
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
